// File: rtl/venda_pkg.sv
// Shared definitions for the vending sale path: FSM states, prices, overflow code, coin codes.
// Latency: n/a (package only).
// Backpressure: n/a; the coin acceptor is held off by controle_venda's ocupado output.
package venda_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    DISPENSA = 2'd1,
    TROCO    = 2'd2,
    LIMPA    = 2'd3
  } estado_t;

  // Prices in quarters (R$0,25 units)
  localparam logic [3:0] PRECO_P0 = 4'd3;
  localparam logic [3:0] PRECO_P1 = 4'd4;
  localparam logic [3:0] PRECO_P2 = 4'd6;
  localparam logic [3:0] PRECO_P3 = 4'd8;

  // Accumulator code meaning "too many coins"
  localparam logic [3:0] CREDITO_OVF = 4'hF;

  // Coin codes shared with the accumulator
  localparam logic [1:0] MOEDA_025 = 2'b01;
  localparam logic [1:0] MOEDA_050 = 2'b10;
  localparam logic [1:0] MOEDA_100 = 2'b11;

  function automatic logic [3:0] preco(input logic [1:0] sel);
    case (sel)
      2'd0:    preco = PRECO_P0;
      2'd1:    preco = PRECO_P1;
      2'd2:    preco = PRECO_P2;
      default: preco = PRECO_P3;
    endcase
  endfunction

endpackage

// File: rtl/temporizador_venda.sv
// Load/count-down timer; fim is high whenever the count sits at zero.
// Latency: carga takes effect on the next edge; a load of K gives fim on the (K+1)th counting edge.
// Backpressure: none; conta simply freezes the count when low.
module temporizador_venda #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic         fim
);

  logic [W-1:0] cnt;

  // Load has priority; counting stops at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (carga)
      cnt <= valor;
    else if (conta && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign fim = (cnt == '0);

endmodule

// File: rtl/controle_venda.sv
// Sale controller: dispense, change, refund and accumulator-clear strobe. Optional macro VENDA_TIMEOUT_EN adds an inactivity refund.
// Latency: confirm at edge N -> dispense N+1..N+DISPENSE_CYCLES, change N+D+1, clear N+D+2; refund at N+1, clear N+2.
// Backpressure: ocupado is high outside ESPERA and blocks the coin acceptor; buttons are ignored while busy.
module controle_venda
  import venda_pkg::*;
#(
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] valorAcumulado,
  input  logic [1:0] selProduto,
  input  logic       confirma,
  input  logic       cancela,
  output logic       tempoLimite,
  output logic       liberaProduto,
  output logic [1:0] produtoLiberado,
  output logic [3:0] troco,
  output logic       trocoValido,
  output logic       estorno,
  output logic       saldoInsuficiente,
  output logic       ocupado
);

  if ((DISPENSE_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_invalido
    $error("controle_venda: DISPENSE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  localparam int WD = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [WD-1:0] CARGA_DISP = WD'(DISPENSE_CYCLES - 1);

  estado_t    estado;
  logic [1:0] sel_lat;
  logic       sobrecarga, cancelar, compra_ok, compra_neg;
  logic       inicia_disp, fim_disp, expirou;

  // Decode of the ESPERA decisions; priority is resolved in the FSM
  always_comb begin
    sobrecarga  = (valorAcumulado == CREDITO_OVF);
    cancelar    = cancela && (valorAcumulado != 4'd0);
    compra_ok   = confirma && (valorAcumulado >= preco(selProduto));
    compra_neg  = confirma && !compra_ok;
    inicia_disp = (estado == ESPERA) && !sobrecarga && !cancelar && compra_ok;
  end

  // Dispense duration: loaded with D-1 when the sale starts, fim ends DISPENSA
  temporizador_venda #(.W(WD)) u_tmr_disp (
    .clk   (clk),
    .reset (reset),
    .carga (inicia_disp),
    .valor (CARGA_DISP),
    .conta (estado == DISPENSA),
    .fim   (fim_disp)
  );

`ifdef VENDA_TIMEOUT_EN
  localparam int WT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WT-1:0] CARGA_TO = WT'(TIMEOUT_CYCLES - 1);

  logic [3:0] valor_ant;
  logic       reinicia, fim_to;

  // Previous credit, to detect coin activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valor_ant <= 4'd0;
    else       valor_ant <= valorAcumulado;
  end

  // Any activity (or no credit) rearms the inactivity window
  always_comb begin
    reinicia = (valorAcumulado == 4'd0) || (valorAcumulado != valor_ant) || confirma || cancela;
    expirou  = (estado == ESPERA) && !reinicia && fim_to;
  end

  temporizador_venda #(.W(WT)) u_tmr_to (
    .clk   (clk),
    .reset (reset),
    .carga ((estado != ESPERA) || reinicia),
    .valor (CARGA_TO),
    .conta (estado == ESPERA),
    .fim   (fim_to)
  );
`else
  assign expirou = 1'b0;
`endif

  // Sale FSM with registered outputs; strobes default low each cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado            <= ESPERA;
      sel_lat           <= 2'd0;
      tempoLimite       <= 1'b0;
      liberaProduto     <= 1'b0;
      produtoLiberado   <= 2'd0;
      troco             <= 4'd0;
      trocoValido       <= 1'b0;
      estorno           <= 1'b0;
      saldoInsuficiente <= 1'b0;
      ocupado           <= 1'b0;
    end else begin
      tempoLimite       <= 1'b0;
      trocoValido       <= 1'b0;
      troco             <= 4'd0;
      estorno           <= 1'b0;
      saldoInsuficiente <= 1'b0;
      case (estado)
        ESPERA: begin
          if (sobrecarga || cancelar) begin
            estorno <= 1'b1;
            ocupado <= 1'b1;
            estado  <= LIMPA;
          end else if (compra_ok) begin
            sel_lat         <= selProduto;
            liberaProduto   <= 1'b1;
            produtoLiberado <= selProduto;
            ocupado         <= 1'b1;
            estado          <= DISPENSA;
          end else if (compra_neg) begin
            saldoInsuficiente <= 1'b1;
          end else if (expirou) begin
            estorno <= 1'b1;
            ocupado <= 1'b1;
            estado  <= LIMPA;
          end
        end
        DISPENSA: begin
          if (fim_disp) begin
            liberaProduto   <= 1'b0;
            produtoLiberado <= 2'd0;
            estado          <= TROCO;
            // Credit cannot shrink, so the subtraction never wraps
            if (sobrecarga) estorno <= 1'b1;
            else begin
              trocoValido <= 1'b1;
              troco       <= valorAcumulado - preco(sel_lat);
            end
          end
        end
        TROCO: begin
          tempoLimite <= 1'b1;
          estado      <= LIMPA;
        end
        LIMPA: begin
          // From TROCO the strobe is already up; from a refund it rises here first
          if (!tempoLimite) tempoLimite <= 1'b1;
          else begin
            ocupado <= 1'b0;
            estado  <= ESPERA;
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_venda.sv
// Scoreboard bench for controle_venda: directed sales, refusals, refunds, late overflow, reset mid-sale.
// Expected events carry the cycle stamp they must appear on; the monitor compares at negedge.
module tb_controle_venda;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valor;
  logic [1:0] sel;
  logic       confirma, cancela;
  logic       tempoLimite, liberaProduto, trocoValido, estorno, saldoInsuficiente, ocupado;
  logic [1:0] produtoLiberado;
  logic [3:0] troco;

  controle_venda #(.DISPENSE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
    .clk               (clk),
    .reset             (reset),
    .valorAcumulado    (valor),
    .selProduto        (sel),
    .confirma          (confirma),
    .cancela           (cancela),
    .tempoLimite       (tempoLimite),
    .liberaProduto     (liberaProduto),
    .produtoLiberado   (produtoLiberado),
    .troco             (troco),
    .trocoValido       (trocoValido),
    .estorno           (estorno),
    .saldoInsuficiente (saldoInsuficiente),
    .ocupado           (ocupado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] t;
    logic        tl;
    logic        lib;
    logic [1:0]  prod;
    logic        tv;
    logic [3:0]  tr;
    logic        est;
    logic        sal;
  } ev_t;

  ev_t esperado[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: every cycle with an active output must match the next expected event
  initial forever begin
    ev_t g, e;
    @(negedge clk);
    if (!reset && (tempoLimite || liberaProduto || trocoValido || estorno || saldoInsuficiente)) begin
      g.t    = cyc;
      g.tl   = tempoLimite;
      g.lib  = liberaProduto;
      g.prod = liberaProduto ? produtoLiberado : 2'd0;
      g.tv   = trocoValido;
      g.tr   = trocoValido ? troco : 4'd0;
      g.est  = estorno;
      g.sal  = saldoInsuficiente;
      total  = total + 1;
      if (esperado.size() == 0) begin
        bad = bad + 1;
        $display("FAIL evento_inesperado got t=%0d tl=%b lib=%b prod=%0d tv=%b troco=%0d est=%b sal=%b want none",
                 g.t, g.tl, g.lib, g.prod, g.tv, g.tr, g.est, g.sal);
      end else begin
        e = esperado.pop_front();
        if (g !== e) begin
          bad = bad + 1;
          $display("FAIL evento got t=%0d tl=%b lib=%b prod=%0d tv=%b troco=%0d est=%b sal=%b want t=%0d tl=%b lib=%b prod=%0d tv=%b troco=%0d est=%b sal=%b",
                   g.t, g.tl, g.lib, g.prod, g.tv, g.tr, g.est, g.sal,
                   e.t, e.tl, e.lib, e.prod, e.tv, e.tr, e.est, e.sal);
        end
      end
    end
  end

  function automatic void ev(input int t, input logic tl, input logic lib, input logic [1:0] pr,
                             input logic tv, input logic [3:0] tr, input logic es, input logic sa);
    ev_t e;
    e.t = t; e.tl = tl; e.lib = lib; e.prod = pr; e.tv = tv; e.tr = tr; e.est = es; e.sal = sa;
    esperado.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Present inputs for one sampling edge n; returns #1 after edge n
  task automatic pulso(input logic [3:0] v, input logic [1:0] s, input logic c, input logic x, output int n);
    @(posedge clk); #1;
    valor = v; sel = s; confirma = c; cancela = x;
    n = cyc + 1;
    @(posedge clk); #1;
    confirma = 1'b0; cancela = 1'b0;
  endtask

  task automatic venda_ok(input logic [3:0] v, input logic [1:0] s, input logic [3:0] tr_esp);
    int n;
    pulso(v, s, 1'b1, 1'b0, n);
    for (int i = 0; i < 4; i++) ev(n + i, 0, 1, s, 0, 4'd0, 0, 0);
    ev(n + 4, 0, 0, 2'd0, 1, tr_esp, 0, 0);
    ev(n + 5, 1, 0, 2'd0, 0, 4'd0, 0, 0);
    chk("ocupado_em_venda", 32'(ocupado), 1);
    repeat (6) @(posedge clk);
    #1 valor = 4'd0;
  endtask

  initial begin
    int n;
    reset = 1'b1; valor = 4'd0; sel = 2'd0; confirma = 1'b0; cancela = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_saidas", 32'({tempoLimite, liberaProduto, produtoLiberado, troco, trocoValido,
                             estorno, saldoInsuficiente, ocupado}), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("ocioso_ocupado", 32'(ocupado), 0);

    // Credit 8, product 2 (price 6): change 2
    venda_ok(4'd8, 2'd2, 4'd2);

    // Credit 2, product 0 (price 3): refused, stays idle
    pulso(4'd2, 2'd0, 1'b1, 1'b0, n);
    ev(n, 0, 0, 2'd0, 0, 4'd0, 0, 1);
    repeat (2) @(posedge clk);
    #1 chk("saldo_insuf_ocupado", 32'(ocupado), 0);
    valor = 4'd0;

    // Credit 5, confirm and cancel together: cancel wins
    pulso(4'd5, 2'd1, 1'b1, 1'b1, n);
    ev(n, 0, 0, 2'd0, 0, 4'd0, 1, 0);
    ev(n + 1, 1, 0, 2'd0, 0, 4'd0, 0, 0);
    chk("cancela_ocupado", 32'(ocupado), 1);
    repeat (3) @(posedge clk);
    #1 valor = 4'd0;

    // Overflow in idle: refund then clear
    pulso(4'hF, 2'd0, 1'b0, 1'b0, n);
    valor = 4'd0;
    ev(n, 0, 0, 2'd0, 0, 4'd0, 1, 0);
    ev(n + 1, 1, 0, 2'd0, 0, 4'd0, 0, 0);
    repeat (3) @(posedge clk);

    // Further sales: exact price, middle product, top product
    venda_ok(4'd3, 2'd0, 4'd0);
    venda_ok(4'd7, 2'd1, 4'd3);
    venda_ok(4'd8, 2'd3, 4'd0);

    // Cancel with zero credit is ignored; confirm with zero credit is refused
    pulso(4'd0, 2'd0, 1'b0, 1'b1, n);
    repeat (2) @(posedge clk);
    pulso(4'd0, 2'd3, 1'b1, 1'b0, n);
    ev(n, 0, 0, 2'd0, 0, 4'd0, 0, 1);
    repeat (2) @(posedge clk);

    // Late coin overflows during dispense: refund instead of change
    pulso(4'd4, 2'd0, 1'b1, 1'b0, n);
    for (int i = 0; i < 4; i++) ev(n + i, 0, 1, 2'd0, 0, 4'd0, 0, 0);
    ev(n + 4, 0, 0, 2'd0, 0, 4'd0, 1, 0);
    ev(n + 5, 1, 0, 2'd0, 0, 4'd0, 0, 0);
    valor = 4'hF;
    repeat (4) @(posedge clk);
    #1 valor = 4'd0;
    repeat (4) @(posedge clk);

`ifdef VENDA_TIMEOUT_EN
    // Inactivity refund, window restarted by a credit change
    pulso(4'd3, 2'd0, 1'b0, 1'b0, n);
    repeat (4) @(posedge clk);
    #1 valor = 4'd4;
    ev(n + 15, 0, 0, 2'd0, 0, 4'd0, 1, 0);
    ev(n + 16, 1, 0, 2'd0, 0, 4'd0, 0, 0);
    repeat (11) @(posedge clk);
    #1 valor = 4'd0;
    repeat (4) @(posedge clk);
`endif

    // Reset in the second dispense cycle aborts everything at once
    pulso(4'd8, 2'd1, 1'b1, 1'b0, n);
    ev(n, 0, 1, 2'd1, 0, 4'd0, 0, 0);
    @(posedge clk);
    #1 chk("dispensa_2o_ciclo", 32'(liberaProduto), 1);
    reset = 1'b1;
    #1;
    chk("reset_meio_saidas", 32'({tempoLimite, liberaProduto, produtoLiberado, troco, trocoValido,
                                  estorno, saldoInsuficiente, ocupado}), 0);
    @(posedge clk);
    #1 reset = 1'b0; valor = 4'd0;
    repeat (3) @(posedge clk);
    #1 chk("pos_reset_ocupado", 32'(ocupado), 0);
    pulso(4'd2, 2'd2, 1'b1, 1'b0, n);
    ev(n, 0, 0, 2'd0, 0, 4'd0, 0, 1);
    repeat (4) @(posedge clk);

    #1 chk("fila_vazia", 32'(esperado.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop guard
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
